// File: rtl/riscv_pkg.sv
// Shared fetch definitions: machine width, PC step, fetch FSM encoding and canonical NOP.
package riscv_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned PC_STEP = 4;
  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_START = 2'd0,
    S_RUN   = 2'd1,
    S_HALT  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry FIFO of packed {pc, instr} words between the memory read port and decode.
module fetch_fifo #(
  parameter int unsigned W = 64
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] data,
  output logic [1:0]   count,
  output logic [W-1:0] head
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         do_push;
  logic         do_pop;

  always_comb begin
    do_pop  = pop && (count != 2'd0);
    do_push = push && ((count < 2'd2) || do_pop);
    head    = mem[rd_ptr];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: PC, one read per cycle, 2-entry buffer toward decode, redirects.
// Optional FETCH_ALIGN_CHECK_EN: misaligned redirect target raises a sticky fault and halts.
module instr_fetch
  import riscv_pkg::*;
#(
  parameter int unsigned      WIDTH    = XLEN,
  parameter int unsigned      DEPTH    = 10,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  output logic             re_o,
  output logic [DEPTH-1:0] addread_o,
  input  logic [WIDTH-1:0] datoread_i,
  input  logic             redirect_i,
  input  logic [WIDTH-1:0] redirect_pc_i,
  output logic             instr_valid_o,
  input  logic             instr_ready_i,
  output logic [WIDTH-1:0] instr_o,
  output logic [WIDTH-1:0] pc_o,
  output logic             fault_o
);

  fetch_state_t       state;
  logic [WIDTH-1:0]   pc;
  logic               fault_q;
  logic [1:0]         count;
  logic [2*WIDTH-1:0] head;
  logic               pop;
  logic               issue;
  logic               redirect;
  logic               misaligned;
  logic [WIDTH-1:0]   aligned_pc;

  always_comb begin
    redirect   = redirect_i && (state != S_HALT);
    aligned_pc = redirect_pc_i & ~WIDTH'(3);
`ifdef FETCH_ALIGN_CHECK_EN
    misaligned = redirect && (redirect_pc_i[1:0] != 2'b00);
`else
    misaligned = 1'b0;
`endif
    instr_valid_o = (state != S_HALT) && (count != 2'd0);
    pop           = instr_valid_o && instr_ready_i;
    // A same-cycle pop frees a slot, so a full buffer still sustains one fetch per cycle.
    issue         = (state == S_RUN) && ((count < 2'd2) || pop) && !redirect_i;
    re_o          = issue;
    addread_o     = pc[DEPTH+1:2];
    {pc_o, instr_o} = instr_valid_o ? head : '0;
    fault_o       = fault_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= S_START;
      pc      <= RESET_PC;
      fault_q <= 1'b0;
    end else if (misaligned) begin
      // Keep the unmasked target in pc for debug.
      state   <= S_HALT;
      fault_q <= 1'b1;
      pc      <= redirect_pc_i;
    end else begin
      if (state == S_START) state <= S_RUN;
      if (redirect)         pc <= aligned_pc;
      else if (issue)       pc <= pc + WIDTH'(PC_STEP);
    end
  end

  fetch_fifo #(
    .W(2 * WIDTH)
  ) u_fifo (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .push  (issue),
    .pop   (pop),
    .flush (redirect),
    .data  ({pc, datoread_i}),
    .count (count),
    .head  (head)
  );

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch against a combinational word memory model.
module tb_instr_fetch;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        re_o;
  logic [9:0]  addread_o;
  logic [31:0] datoread_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic        fault_o;

  logic [31:0] mem [1024];
  int unsigned total = 0;
  int unsigned bad   = 0;

  localparam logic [31:0] W0 = 32'h0050_0293;
  localparam logic [31:0] W1 = 32'h01E0_0313;
  localparam logic [31:0] W2 = 32'h0062_83B3;

  always #5 clk_i = ~clk_i;

  assign datoread_i = mem[addread_o];

  instr_fetch #(
    .WIDTH   (32),
    .DEPTH   (10),
    .RESET_PC(32'h0)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .re_o         (re_o),
    .addread_o    (addread_o),
    .datoread_i   (datoread_i),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .instr_valid_o(instr_valid_o),
    .instr_ready_i(instr_ready_i),
    .instr_o      (instr_o),
    .pc_o         (pc_o),
    .fault_o      (fault_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'hA000_0000 | i;
    mem[0] = W0;
    mem[1] = W1;
    mem[2] = W2;

    rst_ni        = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = '0;
    instr_ready_i = 1'b1;
    #1;
    chk("rst_valid", 32'(instr_valid_o), 32'd0);
    chk("rst_re",    32'(re_o),          32'd0);
    chk("rst_addr",  32'(addread_o),     32'd0);
    chk("rst_instr", instr_o,            32'd0);
    chk("rst_pc",    pc_o,               32'd0);
    chk("rst_fault", 32'(fault_o),       32'd0);

    // Streaming with ready held high
    #11 rst_ni = 1'b1;
    tick();
    chk("start_re",    32'(re_o),          32'd1);
    chk("start_addr",  32'(addread_o),     32'd0);
    chk("start_valid", 32'(instr_valid_o), 32'd0);
    tick();
    chk("s1_valid", 32'(instr_valid_o), 32'd1);
    chk("s1_instr", instr_o, W0);
    chk("s1_pc",    pc_o,    32'h0);
    tick();
    chk("s2_instr", instr_o, W1);
    chk("s2_pc",    pc_o,    32'h4);
    tick();
    chk("s3_instr", instr_o, W2);
    chk("s3_pc",    pc_o,    32'h8);

    // Asynchronous reset between edges
    #2 rst_ni = 1'b0;
    #1;
    chk("arst_valid", 32'(instr_valid_o), 32'd0);
    chk("arst_re",    32'(re_o),          32'd0);
    chk("arst_fault", 32'(fault_o),       32'd0);
    chk("arst_addr",  32'(addread_o),     32'd0);

    // Backpressure: refetch from RESET_PC, ready low for 5 edges after first valid
    instr_ready_i = 1'b0;
    #2 rst_ni = 1'b1;
    tick();
    tick();
    chk("bp_valid", 32'(instr_valid_o), 32'd1);
    chk("bp_instr", instr_o, W0);
    chk("bp_pc0",   pc_o,    32'h0);
    tick();
    chk("bp_full_re", 32'(re_o), 32'd0);
    chk("bp_hold1",   instr_o,   W0);
    tick(); tick(); tick(); tick();
    chk("bp_hold5",  instr_o,        W0);
    chk("bp_re5",    32'(re_o),      32'd0);
    chk("bp_addr5",  32'(addread_o), 32'd2);
    instr_ready_i = 1'b1;
    #1;
    chk("bp_pop_re", 32'(re_o), 32'd1);
    tick();
    chk("bp_next_instr", instr_o, W1);
    chk("bp_next_pc",    pc_o,    32'h4);
    tick();
    chk("bp_next2_instr", instr_o, W2);
    chk("bp_next2_pc",    pc_o,    32'h8);

    // Redirect to 0x100 with the buffer full
    instr_ready_i = 1'b0;
    tick();
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h100;
    #1;
    chk("rd_re_low", 32'(re_o), 32'd0);
    tick();
    redirect_i = 1'b0;
    #1;
    chk("rd_flush_valid", 32'(instr_valid_o), 32'd0);
    chk("rd_re",          32'(re_o),          32'd1);
    chk("rd_addr",        32'(addread_o),     32'h040);
    tick();
    chk("rd_valid", 32'(instr_valid_o), 32'd1);
    chk("rd_pc",    pc_o,    32'h100);
    chk("rd_instr", instr_o, 32'hA000_0040);

    // Redirect to the last word, then wrap of the word address
    instr_ready_i = 1'b1;
    redirect_i    = 1'b1;
    redirect_pc_i = 32'hFFC;
    tick();
    redirect_i = 1'b0;
    #1;
    chk("wrap_addr_top", 32'(addread_o), 32'h3FF);
    tick();
    chk("wrap_instr_top", instr_o,        32'hA000_03FF);
    chk("wrap_pc_top",    pc_o,           32'hFFC);
    chk("wrap_addr0",     32'(addread_o), 32'h000);
    tick();
    chk("wrap_instr0", instr_o, W0);
    chk("wrap_pc",     pc_o,    32'h1000);

    // Misaligned redirect to 0x102
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h102;
    tick();
    redirect_i = 1'b0;
    #1;
`ifdef FETCH_ALIGN_CHECK_EN
    chk("mis_fault", 32'(fault_o),       32'd1);
    chk("mis_re",    32'(re_o),          32'd0);
    chk("mis_valid", 32'(instr_valid_o), 32'd0);
    tick(); tick();
    chk("mis_fault_sticky", 32'(fault_o),       32'd1);
    chk("mis_re_held",      32'(re_o),          32'd0);
    chk("mis_valid_held",   32'(instr_valid_o), 32'd0);
`else
    chk("mis_fault", 32'(fault_o),   32'd0);
    chk("mis_re",    32'(re_o),      32'd1);
    chk("mis_addr",  32'(addread_o), 32'h040);
    tick();
    chk("mis_valid", 32'(instr_valid_o), 32'd1);
    chk("mis_pc",    pc_o,    32'h100);
    chk("mis_instr", instr_o, 32'hA000_0040);
`endif

    #2 rst_ni = 1'b0;
    #1;
    chk("end_fault", 32'(fault_o),       32'd0);
    chk("end_valid", 32'(instr_valid_o), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
